// File: rtl/spi_arb_pkg.sv
// Shared types and limits for the SPI transaction arbiter.
// Holds the arbiter FSM state encoding and the requester-count ceiling.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN
   } state_t;

   localparam int MAX_REQ = 8;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: one-hot grant from a request vector.
// Ports: i_req (requests), i_ptr (first index searched), o_gnt (one-hot).
module spi_rr_picker
   import spi_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt
);

   logic          w_found;
   logic [PW-1:0] w_idx;

   // Walk the requests starting at the pointer, wrapping modulo N.
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = PW'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter streaming multi-byte transfers through one spi_master.
// Ports: req/req_len/tx_data in, gnt/tx_pop/rx_*/done/err/busy out,
// spi_* to the engine. Optional watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int LEN_W          = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic [NUM_REQ*8-1:0]     tx_data,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       tx_pop,
   output logic [7:0]               rx_data,
   output logic [NUM_REQ-1:0]       rx_valid,
   output logic [NUM_REQ-1:0]       done,
   output logic                     err,
   output logic                     busy,
   output logic                     spi_enable,
   output logic [7:0]               spi_wdata,
   input  logic [7:0]               spi_rdata,
   input  logic                     spi_ready,
   input  logic                     spi_cs
);

   localparam int PW  = $clog2(NUM_REQ);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_cfg
      $error("NUM_REQ out of range");
   end

   state_t               r_state, w_state;
   logic [NUM_REQ-1:0]   r_gnt, w_gnt;
   logic [PW-1:0]        r_ptr, w_ptr;
   logic [PW-1:0]        r_own, w_own;
   logic [LEN_W-1:0]     r_cnt, w_cnt;
   logic [7:0]           r_wdata, w_wdata;
   logic                 r_en, w_en;
   logic [NUM_REQ-1:0]   r_pop, w_pop;
   logic [7:0]           r_rxd, w_rxd;
   logic [NUM_REQ-1:0]   r_rxv, w_rxv;
   logic [NUM_REQ-1:0]   r_done, w_done;
   logic                 r_err, w_err;
   logic [WDW-1:0]       r_wd, w_wd;

   logic [NUM_REQ-1:0]   w_pick;
   logic [PW-1:0]        w_pidx;
   logic [LEN_W-1:0]     w_plen;
   logic [7:0]           w_ptx;
   logic [7:0]           w_otx;

   spi_rr_picker #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick)
   );

   // Winner's index/len/byte, and the current owner's next byte.
   always_comb begin
      w_pidx = '0;
      w_plen = '0;
      w_ptx  = '0;
      w_otx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick[i]) begin
            w_pidx = PW'(i);
            w_plen = req_len[i*LEN_W +: LEN_W];
            w_ptx  = tx_data[i*8 +: 8];
         end
         if (r_own == PW'(i)) begin
            w_otx = tx_data[i*8 +: 8];
         end
      end
   end

   always_comb begin
      w_state = r_state;
      w_gnt   = r_gnt;
      w_ptr   = r_ptr;
      w_own   = r_own;
      w_cnt   = r_cnt;
      w_wdata = r_wdata;
      w_en    = r_en;
      w_pop   = '0;
      w_rxd   = r_rxd;
      w_rxv   = '0;
      w_done  = '0;
      w_err   = 1'b0;
      w_wd    = r_wd + WDW'(1);
      unique case (r_state)
         IDLE: begin
            if (|req) begin
               w_state = XFER;
               w_gnt   = w_pick;
               w_own   = w_pidx;
               w_cnt   = w_plen;
               w_wd    = '0;
               w_ptr   = (w_pidx == PW'(NUM_REQ - 1))
                       ? '0 : w_pidx + PW'(1);
               // Zero-length: grant only, no byte leaves.
               if (w_plen != '0) begin
                  w_wdata = w_ptx;
                  w_pop   = w_pick;
                  w_en    = 1'b1;
               end
            end
         end
         XFER: begin
            if (r_cnt == '0) begin
               w_done  = r_gnt;
               w_gnt   = '0;
               w_state = IDLE;
            end else if (spi_ready) begin
               w_rxd = spi_rdata;
               w_rxv = r_gnt;
               w_cnt = r_cnt - LEN_W'(1);
               w_wd  = '0;
               if (r_cnt > LEN_W'(1)) begin
                  w_wdata = w_otx;
                  w_pop   = r_gnt;
               end else begin
                  w_en    = 1'b0;
                  w_done  = r_gnt;
                  w_state = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (spi_cs) begin
               w_gnt   = '0;
               w_state = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      if (r_state == XFER && r_cnt != '0 && !spi_ready &&
          r_wd == WDW'(TIMEOUT_CYCLES - 1)) begin
         w_en    = 1'b0;
         w_err   = 1'b1;
         w_state = DRAIN;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_own   <= '0;
         r_cnt   <= '0;
         r_wdata <= '0;
         r_en    <= 1'b0;
         r_pop   <= '0;
         r_rxd   <= '0;
         r_rxv   <= '0;
         r_done  <= '0;
         r_err   <= 1'b0;
         r_wd    <= '0;
      end else begin
         r_state <= w_state;
         r_gnt   <= w_gnt;
         r_ptr   <= w_ptr;
         r_own   <= w_own;
         r_cnt   <= w_cnt;
         r_wdata <= w_wdata;
         r_en    <= w_en;
         r_pop   <= w_pop;
         r_rxd   <= w_rxd;
         r_rxv   <= w_rxv;
         r_done  <= w_done;
         r_err   <= w_err;
         r_wd    <= w_wd;
      end
   end

   assign gnt        = r_gnt;
   assign tx_pop     = r_pop;
   assign rx_data    = r_rxd;
   assign rx_valid   = r_rxv;
   assign done       = r_done;
   assign busy       = (r_state != IDLE);
   assign spi_enable = r_en;
   assign spi_wdata  = r_wdata;

`ifdef SPI_ARB_TIMEOUT_EN
   assign err = r_err;
`else
   // Watchdog state exists but never fires in this build.
   logic w_unused_wd;
   assign w_unused_wd = r_err ^ (|r_wd);
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a behavioural spi_master model.
// Directed vectors; monitor pops expected events as the DUT pulses them.
module tb_spi_txn_arbiter;

   localparam int NR = 2;
   localparam int LW = 4;
   localparam int BYTE_CYC = 8;
   localparam int K_POP = 0;
   localparam int K_RX = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int         kind;
      int         idx;
      logic [7:0] data;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req;
   logic [NR*LW-1:0] req_len;
   logic [NR*8-1:0] tx_data;
   logic [NR-1:0]   gnt, tx_pop, rx_valid, done;
   logic [7:0]      rx_data, spi_wdata, spi_rdata;
   logic            err, busy, spi_enable, spi_ready, spi_cs;

   ev_t        exp_q[$];
   logic [7:0] rxq[$];
   logic [7:0] tb_tx[NR][16];
   int         tx_ix[NR];
   bit         eng_silent = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   spi_txn_arbiter #(
      .NUM_REQ        (NR),
      .LEN_W          (LW),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_len    (req_len),
      .tx_data    (tx_data),
      .gnt        (gnt),
      .tx_pop     (tx_pop),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .done       (done),
      .err        (err),
      .busy       (busy),
      .spi_enable (spi_enable),
      .spi_wdata  (spi_wdata),
      .spi_rdata  (spi_rdata),
      .spi_ready  (spi_ready),
      .spi_cs     (spi_cs)
   );

   always #5 clk = ~clk;

   always_comb begin
      tx_data = '0;
      for (int i = 0; i < NR; i++)
         tx_data[i*8 +: 8] = tb_tx[i][tx_ix[i]];
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic void push(int k, int i, logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.idx = i;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   task automatic sb(int k, int i, logic [7:0] d);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL sb_unexpected: got kind %0d idx %0d data %0h want none",
                  k, i, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind == k && e.idx == i && e.data == d) n_pass++;
         else $display("FAIL sb_event: got kind %0d idx %0d data %0h want kind %0d idx %0d data %0h",
                       k, i, d, e.kind, e.idx, e.data);
      end
   endtask

   // spi_master model: one byte every BYTE_CYC clocks while enabled.
   initial begin
      int e_cnt;
      bit e_act;
      e_cnt = 0;
      e_act = 1'b0;
      spi_ready = 1'b0;
      spi_cs = 1'b1;
      spi_rdata = '0;
      forever begin
         @(negedge clk);
         spi_ready = 1'b0;
         if (!rst_n) begin
            e_act = 1'b0;
            spi_cs = 1'b1;
         end else if (!e_act) begin
            if (spi_enable) begin
               e_act = 1'b1;
               e_cnt = 0;
               spi_cs = 1'b0;
            end
         end else if (!spi_enable) begin
            e_act = 1'b0;
            spi_cs = 1'b1;
         end else begin
            e_cnt++;
            if (e_cnt == BYTE_CYC && !eng_silent) begin
               e_cnt = 0;
               spi_ready = 1'b1;
               spi_rdata = 8'h00;
               if (rxq.size() > 0) spi_rdata = rxq.pop_front();
            end
         end
      end
   end

   // Monitor: fixed per-cycle order RX, POP, DONE, ERR.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            for (int i = 0; i < NR; i++)
               if (rx_valid[i]) begin
                  sb(K_RX, i, rx_data);
                  chk("en_after_rx", 32'(spi_enable), 32'(done == '0));
               end
            for (int i = 0; i < NR; i++)
               if (tx_pop[i]) sb(K_POP, i, spi_wdata);
            for (int i = 0; i < NR; i++)
               if (done[i]) sb(K_DONE, i, 8'h00);
            if (err) sb(K_ERR, 0, 8'h00);
         end
      end
   end

   // Requester side: advance to the next byte after each pop.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NR; i++)
            if (rst_n && tx_pop[i]) tx_ix[i]++;
      end
   end

   task automatic set_req(logic [NR-1:0] r, int l0, int l1);
      req_len = {LW'(l1), LW'(l0)};
      req = r;
   endtask

   task automatic wait_idle(string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got busy want idle", nm);
      @(negedge clk);
   endtask

   task automatic chk_rst_outs(string nm);
      chk(nm, 32'({gnt, tx_pop, rx_data, rx_valid, done,
                   err, busy, spi_enable, spi_wdata}), 32'd0);
   endtask

   initial begin
      logic [NR-1:0] g[3];
      int ng;
      logic [NR-1:0] prev;
      rst_n = 1'b0;
      set_req('0, 0, 0);
      tx_ix = '{0, 0};
      for (int i = 0; i < NR; i++)
         for (int j = 0; j < 16; j++) tb_tx[i][j] = 8'h00;
      repeat (3) @(negedge clk);
      chk_rst_outs("reset_outputs");
      rst_n = 1'b1;
      @(negedge clk);

      // Single transfer, len 3.
      tb_tx[0][0] = 8'hA5;
      tb_tx[0][1] = 8'h3C;
      tb_tx[0][2] = 8'hFF;
      rxq = '{8'h11, 8'h22, 8'h33};
      push(K_POP, 0, 8'hA5);
      push(K_RX, 0, 8'h11);
      push(K_POP, 0, 8'h3C);
      push(K_RX, 0, 8'h22);
      push(K_POP, 0, 8'hFF);
      push(K_RX, 0, 8'h33);
      push(K_DONE, 0, 8'h00);
      set_req(2'b01, 3, 0);
      @(posedge clk);
      #1;
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_en", 32'(spi_enable), 32'h1);
      @(negedge clk);
      req = '0;
      wait_idle("t1_idle");

      // Contention from reset: 0, then 1, then 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tx_ix = '{0, 0};
      tb_tx[0][0] = 8'h01;
      tb_tx[0][1] = 8'h03;
      tb_tx[1][0] = 8'h02;
      rxq = '{8'h81, 8'h82, 8'h83};
      push(K_POP, 0, 8'h01);
      push(K_RX, 0, 8'h81);
      push(K_DONE, 0, 8'h00);
      push(K_POP, 1, 8'h02);
      push(K_RX, 1, 8'h82);
      push(K_DONE, 1, 8'h00);
      push(K_POP, 0, 8'h03);
      push(K_RX, 0, 8'h83);
      push(K_DONE, 0, 8'h00);
      @(negedge clk);
      set_req(2'b11, 1, 1);
      ng = 0;
      prev = '0;
      g = '{default: '0};
      for (int k = 0; k < 300 && ng < 3; k++) begin
         @(posedge clk);
         #1;
         if (gnt != '0 && prev == '0) begin
            g[ng] = gnt;
            ng++;
         end
         prev = gnt;
      end
      chk("t2_ngrants", 32'(ng), 32'd3);
      chk("t2_gnt0", 32'(g[0]), 32'h1);
      chk("t2_gnt1", 32'(g[1]), 32'h2);
      chk("t2_gnt2", 32'(g[2]), 32'h1);
      @(negedge clk);
      req = '0;
      wait_idle("t2_idle");

      // Zero length on requester 1.
      push(K_DONE, 1, 8'h00);
      set_req(2'b10, 0, 0);
      @(posedge clk);
      #1;
      chk("t3_gnt", 32'(gnt), 32'h2);
      chk("t3_en", 32'(spi_enable), 32'h0);
      @(negedge clk);
      req = '0;
      @(posedge clk);
      #1;
      chk("t3_done_n2", 32'(done), 32'h2);
      chk("t3_gnt_clr", 32'(gnt), 32'h0);
      wait_idle("t3_idle");

      // Request dropped mid-transfer, len 4.
      tx_ix = '{0, 0};
      tb_tx[0][0] = 8'h10;
      tb_tx[0][1] = 8'h20;
      tb_tx[0][2] = 8'h30;
      tb_tx[0][3] = 8'h40;
      rxq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      push(K_POP, 0, 8'h10);
      push(K_RX, 0, 8'hA1);
      push(K_POP, 0, 8'h20);
      push(K_RX, 0, 8'hA2);
      push(K_POP, 0, 8'h30);
      push(K_RX, 0, 8'hA3);
      push(K_POP, 0, 8'h40);
      push(K_RX, 0, 8'hA4);
      push(K_DONE, 0, 8'h00);
      set_req(2'b01, 4, 0);
      repeat (12) @(negedge clk);
      req = '0;
      wait_idle("t4_idle");

      // Reset during byte 2.
      tx_ix = '{0, 0};
      tb_tx[1][0] = 8'h5A;
      tb_tx[1][1] = 8'h6B;
      tb_tx[1][2] = 8'h7C;
      rxq = '{8'hC1, 8'hC2, 8'hC3};
      push(K_POP, 1, 8'h5A);
      push(K_RX, 1, 8'hC1);
      push(K_POP, 1, 8'h6B);
      set_req(2'b10, 0, 3);
      @(posedge clk);
      #1;
      chk("t5_gnt", 32'(gnt), 32'h2);
      repeat (12) @(negedge clk);
      req = '0;
      rst_n = 1'b0;
      #1;
      chk_rst_outs("t5_rst_outs");
      chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rxq.delete();
      tx_ix = '{0, 0};
      tb_tx[0][0] = 8'hE1;
      rxq = '{8'hF1};
      push(K_POP, 0, 8'hE1);
      push(K_RX, 0, 8'hF1);
      push(K_DONE, 0, 8'h00);
      @(negedge clk);
      set_req(2'b11, 1, 1);
      @(posedge clk);
      #1;
      chk("t5_regrant", 32'(gnt), 32'h1);
      @(negedge clk);
      req = '0;
      wait_idle("t5_idle");

`ifdef SPI_ARB_TIMEOUT_EN
      begin
         int k_err;
         eng_silent = 1'b1;
         tx_ix = '{0, 0};
         tb_tx[0][0] = 8'h99;
         push(K_POP, 0, 8'h99);
         push(K_ERR, 0, 8'h00);
         set_req(2'b01, 2, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         req = '0;
         k_err = -1;
         for (int k = 1; k <= 100; k++) begin
            if (k > 1) begin
               @(posedge clk);
               #1;
            end else begin
               @(posedge clk);
               #1;
            end
            if (err) begin
               k_err = k;
               chk("t6_en_off", 32'(spi_enable), 32'h0);
               break;
            end
         end
         chk("t6_err_cycle", 32'(k_err), 32'd64);
         wait_idle("t6_idle");
         eng_silent = 1'b0;
      end
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
